jesd204_adc_chan_pack: RTL
==========================

# jesd204_adc_chan_pack

Packs the per-channel sample stream from the JESD204 ADC transport layer into a dense, gap-free stream containing only the enabled channels. It sits directly downstream of the TPL ADC core and upstream of the DMA write port. Each input beat supplies `SAMPLES_PER_CHANNEL` samples for every channel. Samples from disabled channels are discarded, the remaining samples are concatenated in arrival order, and one full-width word is emitted each time enough samples have accumulated. A dropped output word is reported as an overflow pulse, which feeds `adc_dovf`.

## Interface
- `NUM_CHANNELS`, 4, number of converter channels; power of two, 1..8
- `SAMPLES_PER_CHANNEL`, 1, samples per channel per beat; 1, 2 or 4
- `SAMPLE_WIDTH`, 16, bits per sample; fixed, since the transport uses 2 octets per sample
- Derived: `W = NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH`; `S = NUM_CHANNELS*SAMPLES_PER_CHANNEL`
- `clk`  in  1  link clock; the only clock
- `resetn`  in  1  asynchronous, active-low reset
- `enable`  in  NUM_CHANNELS  channel enable mask, quasi-static, same domain as `clk`
- `in_valid`  in  1  input beat valid; no backpressure to the source
- `in_data`  in  W  channel-major: channel c, sample k at bits `[(c*SPC+k)*16 +: 16]`
- `out_valid`  out  1  packed word available
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  W  packed word; sample j at `[16j +: 16]`, oldest sample at j=0
- `overflow`  out  1  one-cycle pulse per dropped word

## Operation
- **Sample selection and order.** Per accepted beat, the selected samples are, in order: for k=0..SPC-1, for c=0..N-1 with `enable[c]`=1, sample (c,k). The count is `E*SPC`, where E = popcount(enable).
- **Accumulator.** 2*S sample slots plus a fill counter `fill`, range 0..2S-1.
  - A beat appends its selected samples at slot `fill`.
- **Word emission.** If `fill + E*SPC >= S`:
  - slots 0..S-1 form a word;
  - the remainder shifts down to slot 0;
  - `fill` becomes `fill + E*SPC - S`.
- **Arbitrary enable counts.** Any E is legal, including non-powers-of-two; residual samples carry across words.
- **E = 0.** `in_valid` is ignored and no word is ever emitted.
- **Enable change.** `enable` is registered as `enable_q`. When `enable != enable_q`:
  - the accumulator is flushed (`fill` ← 0, partial samples discarded);
  - the beat in that same cycle is discarded;
  - packing resumes with the new mask on the next beat.
  - An already-held output word is not affected.
- **Output register.** One entry, holding `out_valid`/`out_data`.
  - Register empty, or `out_ready`=1 in that cycle: a completed word loads.
  - Register full and `out_ready`=0: the completed word is dropped, `overflow` pulses for one cycle, and the accumulator advances as if the word had been accepted.
- **Output stability.** While `out_valid`=1 and `out_ready`=0, `out_data` holds stable.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `overflow`=0, `fill`=0, `enable_q`=0.
  - The first cycle after reset detects an enable change whenever the mask is non-zero, so the first beat is discarded.
- Latency: a beat that completes a word at edge t has `out_valid`=1 from edge t onward (single register stage).
- Throughput: at most one word per cycle; one word per `S/(E*SPC)` beats on average.
- `out_valid` falls at the edge where `out_valid & out_ready`, unless a new word loads at that same edge.
- `overflow` is registered and asserts at the same edge at which the word would have loaded.
- Reset asserted mid-operation: all state clears asynchronously. There is no partial-word output on release.

## Configuration
- `JESD204_ADC_PACK_DROP_COUNT_EN` defined:
  - adds output `drop_count` [15:0], which counts dropped words and saturates at 0xFFFF;
  - it clears on reset or on any enable change.
- Macro undefined: the port and counter are absent, and `overflow` is the only drop indication.

## Structure
- Package `jesd204_adc_pack_pkg` holds:
  - `SAMPLE_WIDTH` (16);
  - a `popcount` function;
  - a `clog2` function;
  - the typedef for a sample slot.
- Sub-module `jesd204_adc_pack_compress`: combinational. It maps `in_data` and `enable` to a left-justified vector of selected samples plus the count `E*SPC`.
- The top level holds the accumulator, shifter, output register, and overflow/drop logic.

## Test plan
- **All enabled, pass-through.** N=4, SPC=1, enable=4'b1111; beat `in_data`=0x0004_0003_0002_0001 → next cycle `out_valid`=1, `out_data`=0x0004_0003_0002_0001, one word per beat.
- **Two channels.** enable=4'b0101; beats {ch0=A,ch2=B} then {ch0=C,ch2=D} → one word `{D,C,B,A}` after the second beat, and none after the first.
- **Three channels with residual carry.** enable=4'b0111, 4 beats of samples 1..12 → 3 words: `{4,3,2,1}`, `{8,7,6,5}`, `{12,11,10,9}`; `fill`=0 at the end.
- **Drop on full output.** `out_ready`=0 held, all channels enabled, 2 beats → first word held stable; second word dropped with `overflow`=1 for exactly one cycle (`drop_count`=1 if enabled).
- **Enable change mid-word.** enable=4'b0001, 2 beats (fill=2), then enable=4'b0011 → partial discarded; the next 2 beats yield a word of the new samples only.
- **Reset mid-operation.** `resetn` low while `out_valid`=1 and fill=3 → `out_valid`=0 and `overflow`=0 immediately; after release, the first word contains only post-reset samples.

Source files
------------

// File: rtl/jesd204_adc_pack_pkg.sv
// rtl/jesd204_adc_pack_pkg.sv - shared sample type and helper functions for the ADC channel packer
package jesd204_adc_pack_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

    function automatic int popcount(input logic [7:0] mask);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(mask[i]);
        end
        return n;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/jesd204_adc_pack_compress.sv
// rtl/jesd204_adc_pack_compress.sv - gathers enabled-channel samples into a dense, oldest-first vector
module jesd204_adc_pack_compress
    import jesd204_adc_pack_pkg::*;
#(
    parameter int NUM_CHANNELS        = 4,
    parameter int SAMPLES_PER_CHANNEL = 1,
    parameter int COUNT_WIDTH         = 3
) (
    input  logic [NUM_CHANNELS-1:0]                                  enable,
    input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] in_data,
    output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] sel_data,
    output logic [COUNT_WIDTH-1:0]                                   sel_count
);

    logic [7:0] mask;

    always_comb begin : gather
        int idx;
        mask = '0;
        mask[NUM_CHANNELS-1:0] = enable;
        sel_data = '0;
        idx = 0;
        // Sample index is the outer loop so one time instant of all channels stays contiguous.
        for (int k = 0; k < SAMPLES_PER_CHANNEL; k++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (enable[c]) begin
                    sel_data[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                        in_data[(c*SAMPLES_PER_CHANNEL + k)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                    idx++;
                end
            end
        end
        sel_count = COUNT_WIDTH'(popcount(mask) * SAMPLES_PER_CHANNEL);
    end

endmodule

// File: rtl/jesd204_adc_chan_pack.sv
// rtl/jesd204_adc_chan_pack.sv - packs enabled ADC channels into full-width words; JESD204_ADC_PACK_DROP_COUNT_EN adds drop_count
module jesd204_adc_chan_pack
    import jesd204_adc_pack_pkg::*;
#(
    parameter int NUM_CHANNELS        = 4,
    parameter int SAMPLES_PER_CHANNEL = 1
) (
    input  logic                                                     clk,
    input  logic                                                     resetn,
    input  logic [NUM_CHANNELS-1:0]                                  enable,
    input  logic                                                     in_valid,
    input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] in_data,
    output logic                                                     out_valid,
    input  logic                                                     out_ready,
    output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] out_data,
    output logic                                                     overflow
`ifdef JESD204_ADC_PACK_DROP_COUNT_EN
    ,
    output logic [15:0]                                              drop_count
`endif
);

    localparam int S  = NUM_CHANNELS * SAMPLES_PER_CHANNEL;
    localparam int W  = S * SAMPLE_WIDTH;
    localparam int CW = clog2(S + 1);
    localparam int FW = clog2(2 * S);

    logic [W-1:0]            sel_data;
    logic [CW-1:0]           sel_count;

    logic [NUM_CHANNELS-1:0] enable_q, enable_d;
    logic [FW-1:0]           fill_q, fill_d;
    sample_t                 acc_q [2*S];
    sample_t                 acc_d [2*S];
    sample_t                 merged [2*S];
    logic                    out_valid_q, out_valid_d;
    logic [W-1:0]            out_data_q, out_data_d;
    logic                    overflow_q, overflow_d;

    logic                    en_change;
    logic                    word_done;
    logic                    drop;
    logic [W-1:0]            word;
    int                      cnt;
    int                      total;

    jesd204_adc_pack_compress #(
        .NUM_CHANNELS        (NUM_CHANNELS),
        .SAMPLES_PER_CHANNEL (SAMPLES_PER_CHANNEL),
        .COUNT_WIDTH         (CW)
    ) u_compress (
        .enable    (enable),
        .in_data   (in_data),
        .sel_data  (sel_data),
        .sel_count (sel_count)
    );

    always_comb begin
        enable_d  = enable;
        en_change = (enable != enable_q);
        cnt       = (in_valid && !en_change) ? int'(sel_count) : 0;
        total     = int'(fill_q) + cnt;
        word_done = !en_change && (total >= S);

        // New samples land directly behind the residual already held.
        for (int i = 0; i < 2*S; i++) begin
            merged[i] = '0;
            if (i < int'(fill_q)) begin
                merged[i] = acc_q[i];
            end else if ((i - int'(fill_q)) < cnt) begin
                merged[i] = sel_data[(i - int'(fill_q))*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end

        word = '0;
        for (int i = 0; i < S; i++) begin
            word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = merged[i];
        end

        for (int i = 0; i < 2*S; i++) begin
            acc_d[i] = '0;
        end
        fill_d = '0;
        if (en_change) begin
            fill_d = '0;
        end else if (word_done) begin
            for (int i = 0; i < S; i++) begin
                acc_d[i] = merged[i + S];
            end
            fill_d = FW'(total - S);
        end else begin
            for (int i = 0; i < 2*S; i++) begin
                acc_d[i] = merged[i];
            end
            fill_d = FW'(total);
        end

        // The accumulator advances on a drop exactly as if the word had been taken.
        drop        = word_done && out_valid_q && !out_ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overflow_d  = drop;
        if (word_done && !drop) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < 2*S; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            enable_q    <= enable_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < 2*S; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

`ifdef JESD204_ADC_PACK_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (en_change) begin
            drop_count_d = '0;
        end else if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule
